// File: rtl/pipeline_run_ctrl.sv
// ============================================================================
// pipeline_run_ctrl
// ----------------------------------------------------------------------------
// Run/step/halt controller for the five-stage CPU pipeline.
//
// Produces the single enable that advances the PC and every inter-stage
// register (IF/ID, ID/EX, EX/MEM, MEM/WB). The debug unit drives it with
// RUN / STEP / STOP commands. When ID decodes a halt instruction, the
// controller keeps the pipeline enabled just long enough for the older
// instructions to retire through write-back. It then freezes until reset.
//
// Parameters
//   DATA_WIDTH  width of the executed-cycle counter (default 32)
//   NB_STAGES   pipeline depth, 2 or more (default 5). A halt drains
//               NB_STAGES-1 enabled cycles.
//
// Ports
//   clk          in   clock, all state changes on the rising edge
//   i_rst_n      in   asynchronous active-low reset
//   i_cmd_valid  in   command strobe from the debug unit
//   i_cmd[1:0]   in   00 NOP, 01 RUN, 10 STEP, 11 STOP
//   o_cmd_ready  out  command accepted when i_cmd_valid & o_cmd_ready
//   i_halt       in   halt decoded in ID, only looked at while enabled
//   o_pipe_en    out  enable for PC and all pipeline registers
//   o_busy       out  state is RUN, STEP or DRAIN
//   o_halted     out  state is HALTED
//   o_step_done  out  one-cycle pulse after the enabled cycle of a STEP
//   o_cycle_cnt  out  saturating count of enabled cycles
//
// Build option
//   PIPE_CTRL_CYCLE_CNT_EN  when defined, the cycle counter register is
//                           built. Otherwise o_cycle_cnt is tied to zero.
// ============================================================================
module pipeline_run_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int NB_STAGES  = 5
) (
    input  logic                  clk,
    input  logic                  i_rst_n,
    input  logic                  i_cmd_valid,
    input  logic [1:0]            i_cmd,
    output logic                  o_cmd_ready,
    input  logic                  i_halt,
    output logic                  o_pipe_en,
    output logic                  o_busy,
    output logic                  o_halted,
    output logic                  o_step_done,
    output logic [DATA_WIDTH-1:0] o_cycle_cnt
);

    // The drain counter must hold NB_STAGES-2. Its width is clog2 of
    // NB_STAGES-1, with a 1-bit floor so the NB_STAGES=2 build has a
    // legal vector. That build always loads 0 and drains for one cycle.
    localparam int DRAIN_W = (NB_STAGES > 2) ? $clog2(NB_STAGES - 1) : 1;
    localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(NB_STAGES - 2);

    // The NOP command (2'b00) has no constant of its own.
    // It falls into the default arm everywhere a command is decoded.
    localparam logic [1:0] CMD_RUN  = 2'b01;
    localparam logic [1:0] CMD_STEP = 2'b10;
    localparam logic [1:0] CMD_STOP = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RUN    = 3'd1,
        ST_STEP   = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_HALTED = 3'd4
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [DRAIN_W-1:0]   drain_cnt;
    logic [DRAIN_W-1:0]   drain_cnt_nxt;
    logic                 step_done_nxt;
    logic                 cmd_accept;

    // All externally visible status is a pure decode of the state register.
    // This keeps the enable glitch-free, with no combinational path from
    // any input.
    assign o_pipe_en   = (state == ST_RUN) || (state == ST_STEP) || (state == ST_DRAIN);
    assign o_busy      = o_pipe_en;
    assign o_halted    = (state == ST_HALTED);
    assign o_cmd_ready = (state == ST_IDLE) || (state == ST_RUN);

    assign cmd_accept  = i_cmd_valid & o_cmd_ready;

    // State register, drain counter and the step-done pulse.
    // Reset is asynchronous. Pulling i_rst_n low drops the enable at once,
    // even in the middle of a cycle, which freezes the pipeline in place.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= ST_IDLE;
            drain_cnt   <= '0;
            o_step_done <= 1'b0;
        end else begin
            state       <= state_nxt;
            drain_cnt   <= drain_cnt_nxt;
            o_step_done <= step_done_nxt;
        end
    end

    // Next-state logic.
    // i_halt only matters in the states that enable the pipeline, because
    // only then does a new instruction reach ID. In RUN the halt check comes
    // before STOP: a halt already in flight must still drain, even if the
    // debugger asked to stop on the same edge. DRAIN ignores i_halt, since
    // anything behind the halt instruction is younger and must not execute.
    always_comb begin
        state_nxt     = state;
        drain_cnt_nxt = drain_cnt;
        step_done_nxt = 1'b0;

        case (state)
            ST_IDLE: begin
                if (cmd_accept) begin
                    case (i_cmd)
                        CMD_RUN:  state_nxt = ST_RUN;
                        CMD_STEP: state_nxt = ST_STEP;
                        default:  state_nxt = ST_IDLE;
                    endcase
                end
            end

            ST_RUN: begin
                if (i_halt) begin
                    state_nxt     = ST_DRAIN;
                    drain_cnt_nxt = DRAIN_LOAD;
                end else if (cmd_accept && (i_cmd == CMD_STOP)) begin
                    state_nxt = ST_IDLE;
                end
            end

            // A step is exactly one enabled cycle. The done pulse is only
            // raised when the step really ends in IDLE. A step that hits a
            // halt turns into a drain instead.
            ST_STEP: begin
                if (i_halt) begin
                    state_nxt     = ST_DRAIN;
                    drain_cnt_nxt = DRAIN_LOAD;
                end else begin
                    state_nxt     = ST_IDLE;
                    step_done_nxt = 1'b1;
                end
            end

            // The halt edge is itself enabled. The drain then supplies the
            // remaining NB_STAGES-1 enabled edges. Counting down from
            // NB_STAGES-2 to 0 gives exactly that many.
            ST_DRAIN: begin
                if (drain_cnt == '0) begin
                    state_nxt = ST_HALTED;
                end else begin
                    drain_cnt_nxt = drain_cnt - DRAIN_W'(1);
                end
            end

            ST_HALTED: begin
                state_nxt = ST_HALTED;
            end

            default: begin
                state_nxt     = ST_IDLE;
                drain_cnt_nxt = '0;
            end
        endcase
    end

`ifdef PIPE_CTRL_CYCLE_CNT_EN
    logic [DATA_WIDTH-1:0] cycle_cnt;

    // Executed-cycle counter.
    // It advances on every enabled edge and sticks at all-ones rather than
    // wrapping, so a long run never looks like a short one.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cycle_cnt <= '0;
        end else if (o_pipe_en && (cycle_cnt != '1)) begin
            cycle_cnt <= cycle_cnt + DATA_WIDTH'(1);
        end
    end

    assign o_cycle_cnt = cycle_cnt;
`else
    assign o_cycle_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_run_ctrl.sv
// ============================================================================
// tb_pipeline_run_ctrl
// ----------------------------------------------------------------------------
// Directed testbench for pipeline_run_ctrl.
//
// dut  : default build (NB_STAGES=5, DATA_WIDTH=32)
// dut2 : short pipeline (NB_STAGES=2, DATA_WIDTH=4), used for the one-cycle
//        drain and counter saturation cases
//
// The expected cycle counts follow PIPE_CTRL_CYCLE_CNT_EN. With the macro
// undefined, the counter must read zero everywhere.
// ============================================================================
module tb_pipeline_run_ctrl;

    localparam logic [1:0] CMD_NOP  = 2'b00;
    localparam logic [1:0] CMD_RUN  = 2'b01;
    localparam logic [1:0] CMD_STEP = 2'b10;
    localparam logic [1:0] CMD_STOP = 2'b11;

`ifdef PIPE_CTRL_CYCLE_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;

    logic        cmd_valid;
    logic [1:0]  cmd;
    logic        halt;
    logic        cmd_ready;
    logic        pipe_en;
    logic        busy;
    logic        halted;
    logic        step_done;
    logic [31:0] cycle_cnt;

    logic        cmd_valid2;
    logic [1:0]  cmd2;
    logic        halt2;
    logic        cmd_ready2;
    logic        pipe_en2;
    logic        busy2;
    logic        halted2;
    logic        step_done2;
    logic [3:0]  cycle_cnt2;

    int total = 0;
    int bad   = 0;
    int en_cnt = 0;
    int sd_cnt = 0;
    int en_base;
    int sd_base;

    pipeline_run_ctrl #(.DATA_WIDTH(32), .NB_STAGES(5)) dut (
        .clk         (clk),
        .i_rst_n     (rst_n),
        .i_cmd_valid (cmd_valid),
        .i_cmd       (cmd),
        .o_cmd_ready (cmd_ready),
        .i_halt      (halt),
        .o_pipe_en   (pipe_en),
        .o_busy      (busy),
        .o_halted    (halted),
        .o_step_done (step_done),
        .o_cycle_cnt (cycle_cnt)
    );

    pipeline_run_ctrl #(.DATA_WIDTH(4), .NB_STAGES(2)) dut2 (
        .clk         (clk),
        .i_rst_n     (rst_n),
        .i_cmd_valid (cmd_valid2),
        .i_cmd       (cmd2),
        .o_cmd_ready (cmd_ready2),
        .i_halt      (halt2),
        .o_pipe_en   (pipe_en2),
        .o_busy      (busy2),
        .o_halted    (halted2),
        .o_step_done (step_done2),
        .o_cycle_cnt (cycle_cnt2)
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    // Independent tally of enabled cycles and step-done pulses on the
    // default DUT. Sampled mid-cycle, so each count is one enabled edge.
    always @(negedge clk) begin
        if (pipe_en)   en_cnt <= en_cnt + 1;
        if (step_done) sd_cnt <= sd_cnt + 1;
    end

    // Hard time limit so a stuck run still ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int which, input logic v, input logic [1:0] c, input logic h);
        if (which == 0) begin
            cmd_valid = v;
            cmd       = c;
            halt      = h;
        end else begin
            cmd_valid2 = v;
            cmd2       = c;
            halt2      = h;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] expCnt(input int n);
        return CNT_EN ? 32'(n) : 32'd0;
    endfunction

    function automatic logic [31:0] expCnt4(input int n);
        if (!CNT_EN) return 32'd0;
        return (n > 15) ? 32'd15 : 32'(n);
    endfunction

    task automatic resetPulse();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        applyStimulus(0, 1'b0, CMD_NOP, 1'b0);
        applyStimulus(1, 1'b0, CMD_NOP, 1'b0);

        // ---------------- reset values ----------------
        #2;
        checkOutput("rst_pipe_en",   32'(pipe_en),   32'd0);
        checkOutput("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        checkOutput("rst_busy",      32'(busy),      32'd0);
        checkOutput("rst_halted",    32'(halted),    32'd0);
        checkOutput("rst_step_done", 32'(step_done), 32'd0);
        checkOutput("rst_cycle_cnt", cycle_cnt,      32'd0);
        #10;
        rst_n = 1'b1;
        tick();
        checkOutput("idle_pipe_en", 32'(pipe_en), 32'd0);

        // ---------------- run then stop after 10 cycles ----------------
        $display("[TB] run/stop");
        applyStimulus(0, 1'b1, CMD_RUN, 1'b0);
        tick();
        applyStimulus(0, 1'b0, CMD_NOP, 1'b0);
        en_base = en_cnt;
        checkOutput("run_pipe_en",   32'(pipe_en),   32'd1);
        checkOutput("run_busy",      32'(busy),      32'd1);
        checkOutput("run_cmd_ready", 32'(cmd_ready), 32'd1);
        repeat (9) tick();
        applyStimulus(0, 1'b1, CMD_STOP, 1'b0);
        tick();
        applyStimulus(0, 1'b0, CMD_NOP, 1'b0);
        checkOutput("stop_pipe_en",   32'(pipe_en),       32'd0);
        checkOutput("stop_busy",      32'(busy),          32'd0);
        checkOutput("stop_cmd_ready", 32'(cmd_ready),     32'd1);
        checkOutput("stop_en_cycles", 32'(en_cnt - en_base), 32'd10);
        checkOutput("stop_cycle_cnt", cycle_cnt,          expCnt(10));
        tick();
        checkOutput("stop_frozen",    32'(pipe_en),       32'd0);

        // ---------------- asynchronous reset mid-RUN ----------------
        $display("[TB] mid-run reset");
        applyStimulus(0, 1'b1, CMD_RUN, 1'b0);
        tick();
        applyStimulus(0, 1'b0, CMD_NOP, 1'b0);
        repeat (3) tick();
        checkOutput("pre_rst_pipe_en", 32'(pipe_en), 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("mrst_pipe_en",   32'(pipe_en),   32'd0);
        checkOutput("mrst_busy",      32'(busy),      32'd0);
        checkOutput("mrst_cmd_ready", 32'(cmd_ready), 32'd1);
        checkOutput("mrst_cycle_cnt", cycle_cnt,      32'd0);
        #2;
        rst_n = 1'b1;
        tick();
        checkOutput("mrst_idle_en",   32'(pipe_en),   32'd0);

        // ---------------- three steps, STEP held while stepping ----------------
        $display("[TB] step");
        en_base = en_cnt;
        sd_base = sd_cnt;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 1'b1, CMD_STEP, 1'b0);
            tick();
            checkOutput("step_pipe_en",   32'(pipe_en),   32'd1);
            checkOutput("step_cmd_ready", 32'(cmd_ready), 32'd0);
            checkOutput("step_done_early", 32'(step_done), 32'd0);
            tick();
            applyStimulus(0, 1'b0, CMD_NOP, 1'b0);
            checkOutput("step_end_en",    32'(pipe_en),   32'd0);
            checkOutput("step_done",      32'(step_done), 32'd1);
            tick();
            checkOutput("step_done_clr",  32'(step_done), 32'd0);
            checkOutput("step_dropped",   32'(pipe_en),   32'd0);
        end
        checkOutput("step_en_cycles", 32'(en_cnt - en_base), 32'd3);
        checkOutput("step_pulses",    32'(sd_cnt - sd_base), 32'd3);
        checkOutput("step_cycle_cnt", cycle_cnt,            expCnt(3));

        // ---------------- halt at enabled edge 7, drain 4 ----------------
        $display("[TB] halt drain");
        resetPulse();
        applyStimulus(0, 1'b1, CMD_RUN, 1'b0);
        tick();
        applyStimulus(0, 1'b0, CMD_NOP, 1'b0);
        en_base = en_cnt;
        repeat (6) tick();
        applyStimulus(0, 1'b0, CMD_NOP, 1'b1);
        tick();
        applyStimulus(0, 1'b0, CMD_NOP, 1'b0);
        checkOutput("drain_busy",      32'(busy),      32'd1);
        checkOutput("drain_cmd_ready", 32'(cmd_ready), 32'd0);
        checkOutput("drain_halted",    32'(halted),    32'd0);
        repeat (3) tick();
        checkOutput("drain_late_halted", 32'(halted),  32'd0);
        checkOutput("drain_late_en",     32'(pipe_en), 32'd1);
        tick();
        checkOutput("halted",           32'(halted),    32'd1);
        checkOutput("halted_pipe_en",   32'(pipe_en),   32'd0);
        checkOutput("halted_busy",      32'(busy),      32'd0);
        checkOutput("halted_cmd_ready", 32'(cmd_ready), 32'd0);
        checkOutput("halt_en_cycles",   32'(en_cnt - en_base), 32'd11);
        checkOutput("halt_cycle_cnt",   cycle_cnt,      expCnt(11));
        applyStimulus(0, 1'b1, CMD_RUN, 1'b0);
        repeat (2) tick();
        applyStimulus(0, 1'b1, CMD_STEP, 1'b0);
        repeat (2) tick();
        applyStimulus(0, 1'b0, CMD_NOP, 1'b0);
        checkOutput("halted_sticky",    32'(halted),    32'd1);
        checkOutput("halted_ignore_en", 32'(en_cnt - en_base), 32'd11);
        checkOutput("halted_cnt_hold",  cycle_cnt,      expCnt(11));

        // ---------------- halt and stop on the same RUN edge ----------------
        $display("[TB] halt/stop collision");
        resetPulse();
        applyStimulus(0, 1'b1, CMD_RUN, 1'b0);
        applyStimulus(1, 1'b1, CMD_RUN, 1'b0);
        tick();
        applyStimulus(0, 1'b0, CMD_NOP, 1'b0);
        applyStimulus(1, 1'b0, CMD_NOP, 1'b0);
        repeat (2) tick();
        applyStimulus(0, 1'b1, CMD_STOP, 1'b1);
        applyStimulus(1, 1'b1, CMD_STOP, 1'b1);
        tick();
        applyStimulus(0, 1'b0, CMD_NOP, 1'b0);
        applyStimulus(1, 1'b0, CMD_NOP, 1'b0);
        checkOutput("coll_busy",       32'(busy),       32'd1);
        checkOutput("coll_cmd_ready",  32'(cmd_ready),  32'd0);
        checkOutput("coll_halted",     32'(halted),     32'd0);
        checkOutput("coll2_busy",      32'(busy2),      32'd1);
        checkOutput("coll2_halted",    32'(halted2),    32'd0);
        tick();
        checkOutput("coll2_halted_1",  32'(halted2),    32'd1);
        checkOutput("coll2_pipe_en",   32'(pipe_en2),   32'd0);
        checkOutput("coll_not_yet",    32'(halted),     32'd0);
        repeat (3) tick();
        checkOutput("coll_halted_4",   32'(halted),     32'd1);
        checkOutput("coll_cycle_cnt",  cycle_cnt,       expCnt(7));
        checkOutput("coll2_cycle_cnt", 32'(cycle_cnt2), expCnt4(4));

        // ---------------- 4-bit counter saturation ----------------
        $display("[TB] saturation");
        resetPulse();
        applyStimulus(1, 1'b1, CMD_RUN, 1'b0);
        tick();
        applyStimulus(1, 1'b0, CMD_NOP, 1'b0);
        repeat (14) tick();
        checkOutput("sat_cnt_14", 32'(cycle_cnt2), expCnt4(14));
        repeat (6) tick();
        checkOutput("sat_cnt_20", 32'(cycle_cnt2), expCnt4(20));
        applyStimulus(1, 1'b1, CMD_STOP, 1'b0);
        tick();
        applyStimulus(1, 1'b0, CMD_NOP, 1'b0);
        checkOutput("sat_stop_busy", 32'(busy2),   32'd0);
        checkOutput("sat_other_cnt", cycle_cnt,    32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
